wb_timer: RTL and testbench
===========================

# wb_timer

Wishbone-pipelined timer peripheral that hangs off one slave port of `wb_multiplexer`, beside the LED and ROM slaves. It provides a free-running 32-bit counter, a compare register with a sticky match flag, and an interrupt line, so bus masters can time LED sequences without busy-loop counting. The slave never stalls, and every accepted request is acknowledged exactly one cycle later.

## Interface
- `DataWidth`, 32, bus data width; fixed, localparam.
- `AddrWidth`, 32, bus address width; fixed, localparam.
- `SelWidth`, 4, byte-select width (`DataWidth/8`); fixed, localparam.
- `clk` in 1: clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `bus_data_m` in 32: write data from the master.
- `bus_addr` in 32: byte address; only `bus_addr[4:2]` is decoded.
- `bus_sel` in 4: byte enables for writes.
- `bus_cyc` in 1: cycle valid.
- `bus_stb` in 1: request strobe.
- `bus_we` in 1: 1 = write, 0 = read.
- `bus_data_s` out 32: read data, valid while `bus_ack` = 1.
- `bus_ack` out 1: acknowledge.
- `bus_stall` out 1: tied to 0.
- `bus_err` out 1: tied to 0.
- `irq` out 1: level interrupt, equal to `STATUS.match & CTRL.irq_en`.

## Operation
- Register map, word offset `bus_addr[4:2]`:
  - 0 CTRL: bit0 `enable`, bit1 `autoreload`, bit2 `irq_en`; other bits read 0.
  - 1 COUNT: read/write counter.
  - 2 COMPARE: read/write.
  - 3 STATUS: bit0 `match`; writing 1 to bit0 clears it (W1C).
  - 4 PRESCALE: only with the macro; see Configuration.
  - Offsets 5–7: read 0, writes ignored.
- Accepting requests:
  - A request is accepted when `bus_cyc & bus_stb & !bus_stall`.
  - Writes honour `bus_sel` per byte; `sel = 0` writes nothing but is still acked.
- Tick:
  - One tick per enabled count step. Without the macro, tick = `enable` every cycle.
- On a tick:
  - If COUNT == COMPARE: set `match`; COUNT ← 0 if `autoreload`, else COUNT+1.
  - Otherwise COUNT ← COUNT+1.
  - Increment wraps from 0xFFFF_FFFF to 0 with no flag.
- Simultaneous events:
  - A bus write to COUNT in the same cycle as a tick wins; the written value is stored and there is no increment.
  - A match is evaluated against the pre-write COUNT and COMPARE.
  - A `match` set and a W1C clear in the same cycle: set wins, flag stays 1.
- Clearing `enable` freezes COUNT; `match` is retained.

## Timing
- Reset values: all registers 0; `bus_ack` = 0; `bus_data_s` = 0; `irq` = 0.
- Latency:
  - `bus_ack` is registered: `bus_ack` ← `bus_cyc & bus_stb`, one cycle after acceptance.
  - Read data is registered in the same cycle as the ack.
  - Register writes take effect on the accepting edge and are visible to the next request.
- Throughput: back-to-back strobes on consecutive cycles produce acks on consecutive cycles, one per strobe, in order.
- Read data:
  - Reflects register state before the accepting edge.
  - A COUNT read returns the value sampled at acceptance, not the incremented value.
- `bus_cyc` dropped: acks already in flight still pulse; the master ignores them. No internal state depends on the ack.
- `irq`:
  - Combinational from registered `match` and `irq_en`.
  - Rises the cycle after the matching tick's edge.
  - Falls the cycle after the W1C edge.
- Reset mid-operation: all state returns to reset values on the next edge; an in-flight ack is suppressed.

## Configuration
- Macro: `WB_TIMER_PRESCALER_EN`.
- Defined:
  - Offset 4 becomes a 16-bit PRESCALE register; bits 31:16 read 0.
  - A 16-bit prescale counter counts cycles while `enable` = 1, and tick fires when it equals PRESCALE. The prescale counter then resets to 0, so there is one tick every PRESCALE+1 cycles.
  - The prescale counter clears on `enable` = 0 and on any write to PRESCALE.
- Undefined:
  - Offset 4 reads 0 and ignores writes.
  - Tick = `enable`, one per cycle.

## Test plan
- Reset, then read all offsets 0–7 -> every read returns 0; `bus_ack` one cycle after each stb; `bus_stall` = 0 throughout.
- COMPARE = 5, CTRL = 0x7 -> COUNT runs 0..5, `match` = 1 and `irq` = 1 after the tick at 5, COUNT = 0 next; W1C STATUS = 1 -> `irq` = 0 next cycle.
- COUNT = 0xFFFF_FFFE, CTRL = 0x1, COMPARE = 3 -> COUNT sequence FFFF_FFFE, FFFF_FFFF, 0, 1; `match` stays 0 until 3.
- Write COUNT = 0x100 with `bus_sel` = 4'b0010 while counting -> byte 1 replaced; write wins over same-cycle tick; other bytes unchanged.
- Four back-to-back strobes: write COMPARE, read COMPARE, write CTRL, read CTRL -> 4 consecutive acks; reads return the newly written values.
- With `WB_TIMER_PRESCALER_EN`: PRESCALE = 3, CTRL = 0x1 -> COUNT increments every 4 cycles. Without it -> offset 4 reads 0 and COUNT increments every cycle.

Source files
------------

// File: rtl/wb_timer.sv
// wb_timer: Wishbone-pipelined timer slave.
// It has a free-running 32-bit counter, a compare register, a sticky match flag
// and a level interrupt line.
// Optional feature: define WB_TIMER_PRESCALER_EN to add a 16-bit PRESCALE
// register at word offset 4 and a prescale counter that gates the count tick.
module wb_timer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] bus_data_m,
  input  logic [31:0] bus_addr,
  input  logic [3:0]  bus_sel,
  input  logic        bus_cyc,
  input  logic        bus_stb,
  input  logic        bus_we,
  output logic [31:0] bus_data_s,
  output logic        bus_ack,
  output logic        bus_stall,
  output logic        bus_err,
  output logic        irq
);

  localparam int DataWidth = 32;
  localparam int AddrWidth = 32;
  localparam int SelWidth  = DataWidth / 8;

  logic [2:0]           ctrl;      // {irq_en, autoreload, enable}
  logic [DataWidth-1:0] count;
  logic [DataWidth-1:0] compare;
  logic                 match;

  logic                 accept;
  logic                 wr;
  logic [2:0]           idx;
  logic                 tick;
  logic                 hit;
  logic [DataWidth-1:0] rdata_p0;

  // Only word offset bits are decoded; the remaining address bits are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus_addr[AddrWidth-1:5], bus_addr[1:0]};

  // Byte-lane merge of write data into an existing register value.
  function automatic logic [DataWidth-1:0] merge_bytes(
    input logic [DataWidth-1:0] old_val,
    input logic [DataWidth-1:0] new_val,
    input logic [SelWidth-1:0]  sel
  );
    logic [DataWidth-1:0] res;
    res = old_val;
    for (int b = 0; b < SelWidth; b++) begin
      if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  assign bus_stall = 1'b0;
  assign bus_err   = 1'b0;
  assign accept    = bus_cyc & bus_stb & ~bus_stall;
  assign wr        = accept & bus_we;
  assign idx       = bus_addr[4:2];
  assign hit       = tick && (count == compare);
  assign irq       = match & ctrl[2];

`ifdef WB_TIMER_PRESCALER_EN
  logic [15:0] prescale;
  logic [15:0] pre_cnt;

  assign tick = ctrl[0] && (pre_cnt == prescale);

  // Prescale register and cycle counter; a tick fires once every PRESCALE+1 enabled cycles.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prescale <= '0;
      pre_cnt  <= '0;
    end else begin
      if (wr && idx == 3'd4) begin
        if (bus_sel[0]) prescale[7:0]  <= bus_data_m[7:0];
        if (bus_sel[1]) prescale[15:8] <= bus_data_m[15:8];
      end
      if (!ctrl[0] || (wr && idx == 3'd4) || tick) pre_cnt <= '0;
      else                                           pre_cnt <= pre_cnt + 16'd1;
    end
  end
`else
  assign tick = ctrl[0];
`endif

  // Read mux over the register state as it stands before the accepting edge.
  always_comb begin
    rdata_p0 = '0;
    case (idx)
      3'd0: rdata_p0 = {29'd0, ctrl};
      3'd1: rdata_p0 = count;
      3'd2: rdata_p0 = compare;
      3'd3: rdata_p0 = {31'd0, match};
`ifdef WB_TIMER_PRESCALER_EN
      3'd4: rdata_p0 = {16'd0, prescale};
`endif
      default: rdata_p0 = '0;
    endcase
  end

  // Register file, counter and sticky match; a bus write to COUNT beats a same-cycle tick.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl    <= '0;
      count   <= '0;
      compare <= '0;
      match   <= 1'b0;
    end else begin
      if (wr && idx == 3'd0 && bus_sel[0]) ctrl <= bus_data_m[2:0];
      if (wr && idx == 3'd2) compare <= merge_bytes(compare, bus_data_m, bus_sel);

      if (wr && idx == 3'd1)     count <= merge_bytes(count, bus_data_m, bus_sel);
      else if (hit && ctrl[1])   count <= '0;
      else if (tick)             count <= count + 32'd1;

      // A set in the same cycle as a W1C clear keeps the flag high.
      if (hit)                                                    match <= 1'b1;
      else if (wr && idx == 3'd3 && bus_sel[0] && bus_data_m[0]) match <= 1'b0;
    end
  end

  // ---- stage p1: registered ack and read data, one cycle after acceptance ----
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus_ack    <= 1'b0;
      bus_data_s <= '0;
    end else begin
      bus_ack    <= accept;
      bus_data_s <= accept ? rdata_p0 : '0;
    end
  end

endmodule

// File: tb/tb_wb_timer.sv
// tb_wb_timer: directed plus randomized bench for wb_timer.
// A behavioural model of the register map is stepped on every clock edge and a
// compare process checks ack, read data and irq against it on every falling edge.
module tb_wb_timer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] bus_data_m;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic        bus_cyc;
  logic        bus_stb;
  logic        bus_we;
  logic [31:0] bus_data_s;
  logic        bus_ack;
  logic        bus_stall;
  logic        bus_err;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  wb_timer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus_data_m(bus_data_m),
    .bus_addr  (bus_addr),
    .bus_sel   (bus_sel),
    .bus_cyc   (bus_cyc),
    .bus_stb   (bus_stb),
    .bus_we    (bus_we),
    .bus_data_s(bus_data_s),
    .bus_ack   (bus_ack),
    .bus_stall (bus_stall),
    .bus_err   (bus_err),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] m_reg [0:7];   // architectural view: 0 ctrl, 1 count, 2 compare, 3 status, 4 prescale
  int unsigned m_pcnt;
  logic        m_valid = 1'b0;
  logic        exp_ack;
  logic [31:0] exp_data;
  logic        exp_irq;

  function automatic bit has_prescaler();
`ifdef WB_TIMER_PRESCALER_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Advance the model by one clock edge using the inputs held across that edge.
  task automatic model_step();
    logic        acc, w, tk, hit, en, autoreload;
    int          a;
    logic [31:0] rd, cnt, cmp, nv;
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) m_reg[i] = 32'd0;
      m_pcnt   = 0;
      exp_ack  = 1'b0;
      exp_data = 32'd0;
      exp_irq  = 1'b0;
      m_valid  = 1'b1;
      return;
    end
    acc = bus_cyc & bus_stb;
    w   = acc & bus_we;
    a   = int'(bus_addr[4:2]);
    rd  = (a <= 3 || (a == 4 && has_prescaler())) ? m_reg[a] : 32'd0;
    en         = m_reg[0][0];
    autoreload = m_reg[0][1];
    cnt = m_reg[1];
    cmp = m_reg[2];
    tk  = has_prescaler() ? (en && m_pcnt == m_reg[4]) : en;
    hit = tk && (cnt == cmp);
    // prescale counter
    if (has_prescaler()) begin
      if (!en || (w && a == 4) || tk) m_pcnt = 0;
      else                            m_pcnt = m_pcnt + 1;
    end
    // count: write beats tick
    if (w && a == 1) begin
      nv = cnt;
      for (int b = 0; b < 4; b++) if (bus_sel[b]) nv[8*b +: 8] = bus_data_m[8*b +: 8];
      m_reg[1] = nv;
    end else if (tk) begin
      m_reg[1] = (hit && autoreload) ? 32'd0 : cnt + 32'd1;
    end
    if (w && a == 2)
      for (int b = 0; b < 4; b++) if (bus_sel[b]) m_reg[2][8*b +: 8] = bus_data_m[8*b +: 8];
    if (w && a == 0 && bus_sel[0]) m_reg[0] = {29'd0, bus_data_m[2:0]};
    if (w && a == 4 && has_prescaler()) begin
      if (bus_sel[0]) m_reg[4][7:0]  = bus_data_m[7:0];
      if (bus_sel[1]) m_reg[4][15:8] = bus_data_m[15:8];
    end
    if (hit) m_reg[3] = 32'd1;
    else if (w && a == 3 && bus_sel[0] && bus_data_m[0]) m_reg[3] = 32'd0;
    exp_ack  = acc;
    exp_data = acc ? rd : 32'd0;
    exp_irq  = m_reg[3][0] & m_reg[0][2];
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if (bus_ack !== exp_ack) begin
        failures++;
        $display("FAIL ack: got %b expected %b at %0t", bus_ack, exp_ack, $time);
      end
      checks++;
      if (irq !== exp_irq) begin
        failures++;
        $display("FAIL irq: got %b expected %b at %0t", irq, exp_irq, $time);
      end
      checks++;
      if (bus_stall !== 1'b0 || bus_err !== 1'b0) begin
        failures++;
        $display("FAIL stall_err: got %b%b expected 00 at %0t", bus_stall, bus_err, $time);
      end
      if (exp_ack) begin
        checks++;
        if (bus_data_s !== exp_data) begin
          failures++;
          $display("FAIL rdata: got %h expected %h at %0t", bus_data_s, exp_data, $time);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One bus cycle: drive, cross the edge, step the model, capture at the falling edge.
  task automatic cycle(input logic cyc, input logic stb, input logic we, input logic [2:0] idx,
                       input logic [31:0] data, input logic [3:0] sel,
                       output logic [31:0] rdata, output logic ack);
    bus_cyc    = cyc;
    bus_stb    = stb;
    bus_we     = we;
    bus_addr   = {27'd0, idx, 2'b00};
    bus_data_m = data;
    bus_sel    = sel;
    @(posedge clk);
    model_step();
    @(negedge clk);
    rdata = bus_data_s;
    ack   = bus_ack;
  endtask

  task automatic wr_reg(input logic [2:0] idx, input logic [31:0] data, input logic [3:0] sel);
    logic [31:0] d;
    logic        k;
    cycle(1'b1, 1'b1, 1'b1, idx, data, sel, d, k);
  endtask

  task automatic rd_reg(input logic [2:0] idx, output logic [31:0] d, output logic ack);
    cycle(1'b1, 1'b1, 1'b0, idx, 32'd0, 4'hF, d, ack);
  endtask

  task automatic idle(input int n);
    logic [31:0] d;
    logic        k;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 4'h0, d, k);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] d;
    logic        k;
    int          waited;
    reset_n = 1'b0;
    bus_cyc = 1'b0; bus_stb = 1'b0; bus_we = 1'b0;
    bus_addr = 32'd0; bus_data_m = 32'd0; bus_sel = 4'h0;
    @(negedge clk);
    idle(2);
    reset_n = 1'b1;

    // all offsets read zero after reset
    for (int i = 0; i < 8; i++) begin
      rd_reg(3'(i), d, k);
      chk($sformatf("reset_read_%0d", i), d, 32'd0);
      chk($sformatf("reset_ack_%0d", i), {31'd0, k}, 32'd1);
    end

    // compare match with autoreload and irq
    wr_reg(3'd2, 32'd5, 4'hF);
    wr_reg(3'd0, 32'd7, 4'hF);
    waited = 0;
    while (irq !== 1'b1 && waited < 40) begin
      idle(1);
      waited++;
    end
    chk("irq_rise", {31'd0, irq}, 32'd1);
    rd_reg(3'd1, d, k);
    chk("count_after_reload", d, 32'd0);
    wr_reg(3'd0, 32'd4, 4'hF);
    rd_reg(3'd3, d, k);
    chk("status_match", d, 32'd1);
    wr_reg(3'd3, 32'd1, 4'hF);
    chk("irq_fall", {31'd0, irq}, 32'd0);

    // wrap from 0xFFFF_FFFE
    wr_reg(3'd1, 32'hFFFF_FFFE, 4'hF);
    wr_reg(3'd2, 32'd3, 4'hF);
    wr_reg(3'd0, 32'd1, 4'hF);
    rd_reg(3'd1, d, k); chk("wrap0", d, 32'hFFFF_FFFE);
    rd_reg(3'd1, d, k); chk("wrap1", d, 32'hFFFF_FFFF);
    rd_reg(3'd1, d, k); chk("wrap2", d, 32'h0000_0000);
    rd_reg(3'd1, d, k); chk("wrap3", d, 32'h0000_0001);
    rd_reg(3'd3, d, k); chk("no_match_on_wrap", d, 32'd0);

    // partial byte write of COUNT while counting, same edge as a matching tick
    wr_reg(3'd1, 32'h0000_0100, 4'b0010);
    rd_reg(3'd1, d, k); chk("sel_write_count", d, 32'h0000_0103);
    rd_reg(3'd3, d, k); chk("match_prewrite", d, 32'd1);

    // four back-to-back strobes
    wr_reg(3'd2, 32'h55, 4'hF);
    rd_reg(3'd2, d, k); chk("b2b_compare", d, 32'h55); chk("b2b_ack1", {31'd0, k}, 32'd1);
    wr_reg(3'd0, 32'd2, 4'hF);
    rd_reg(3'd0, d, k); chk("b2b_ctrl", d, 32'd2);     chk("b2b_ack3", {31'd0, k}, 32'd1);

    // offset 4 and tick rate
    wr_reg(3'd4, 32'd3, 4'hF);
    rd_reg(3'd4, d, k);
    chk("offset4", d, has_prescaler() ? 32'd3 : 32'd0);
    wr_reg(3'd1, 32'd0, 4'hF);
    wr_reg(3'd0, 32'd1, 4'hF);
    idle(8);
    rd_reg(3'd1, d, k);
    chk("tick_rate", d, has_prescaler() ? 32'd2 : 32'd8);

    // randomized traffic with occasional mid-operation reset
    for (int n = 0; n < 600; n++) begin
      logic [2:0]  ridx;
      logic [31:0] rdat;
      ridx = 3'($urandom_range(0, 7));
      case (ridx)
        3'd0:    rdat = 32'($urandom_range(0, 7)) | (32'($urandom) & 32'hFFFF_FF00);
        3'd1,
        3'd2:    rdat = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 12));
        3'd4:    rdat = 32'($urandom_range(0, 3));
        default: rdat = $urandom;
      endcase
      reset_n = ($urandom_range(0, 99) != 0);
      bus_cyc    = ($urandom_range(0, 3) != 0);
      bus_stb    = ($urandom_range(0, 3) != 0);
      bus_we     = $urandom_range(0, 1) == 1;
      bus_addr   = {$urandom_range(0, 1) == 1 ? 27'h5A5A5A5 : 27'd0, ridx, 2'($urandom_range(0, 3))};
      bus_data_m = rdat;
      bus_sel    = 4'($urandom_range(0, 15));
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
    reset_n = 1'b1;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
